mem_stage_lsu: RTL and testbench

- Load/store unit for the MEM stage of the 5-stage pipeline; directly upstream of the MEM/WB pipeline register.
- Takes the memory-op fields from EX/MEM and runs a req/ack transaction with the data memory.
- Aligns store data and byte enables, and sign/zero-extends load data.
- Produces the load-result word (feeds MEM/WB load-data input), the MEM/WB write enable, and a pipeline stall.

---
 rtl/mem_stage_lsu_pkg.sv | 48 ++++
 rtl/mem_stage_lsu_if.sv | 22 ++
 rtl/mem_stage_lsu_align.sv | 64 ++++++
 rtl/mem_stage_lsu.sv | 154 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM state encoding, byte-enable constants and access-size helpers.
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Reserved funct3 codes fall into the word bucket.
  function automatic acc_size_t access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

  // Halfwords need a[0] = 0, words need a[1:0] = 00.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (access_size(funct3))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/ack bus between the LSU (master) and data memory (slave).
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 12
);
  logic              D_MEM_REQ;
  logic              D_MEM_WEN;
  logic [ADDR_W-1:0] D_MEM_ADDR;
  logic [3:0]        D_MEM_BE;
  logic [31:0]       D_MEM_DOUT;
  logic [31:0]       D_MEM_DI;
  logic              D_MEM_ACK;

  modport master (
    output D_MEM_REQ, D_MEM_WEN, D_MEM_ADDR, D_MEM_BE, D_MEM_DOUT,
    input  D_MEM_DI, D_MEM_ACK
  );

  modport slave (
    input  D_MEM_REQ, D_MEM_WEN, D_MEM_ADDR, D_MEM_BE, D_MEM_DOUT,
    output D_MEM_DI, D_MEM_ACK
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane steering for the LSU: store byte enables and
// replicated store data, plus load byte/halfword extraction and extension.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic        st_write,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_dout,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  // Stores place the operand on every lane and let BE pick; loads read all four bytes.
  always_comb begin
    st_be   = BE_ALL;
    st_dout = st_data;
    if (st_write) begin
      case (access_size(st_funct3))
        SZ_BYTE: begin
          st_be   = BE_BYTE0 << st_addr_lo;
          st_dout = {4{st_data[7:0]}};
        end
        SZ_HALF: begin
          st_be   = st_addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
          st_dout = {2{st_data[15:0]}};
        end
        default: begin
          st_be   = BE_ALL;
          st_dout = st_data;
        end
      endcase
    end
  end

  // Pick the addressed byte/halfword and extend it; funct3[2] marks the unsigned forms.
  always_comb begin
    ld_byte   = ld_raw[7:0];
    ld_half   = ld_raw[15:0];
    ld_signed = ~ld_funct3[2];
    ld_data   = ld_raw;
    case (ld_addr_lo)
      2'b00:   ld_byte = ld_raw[7:0];
      2'b01:   ld_byte = ld_raw[15:8];
      2'b10:   ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    if (ld_addr_lo[1]) ld_half = ld_raw[31:16];
    case (access_size(ld_funct3))
      SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts a memory op from EX/MEM, runs one
// req/ack transaction on the data-memory bus, and hands MEM/WB the load
// result with a write enable while stalling the front of the pipe.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip
// the bus and finish with bus_err; otherwise the low address bits are ignored.
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   valid_MEM,
  input  logic                   MemRead_MEM,
  input  logic                   MemWrite_MEM,
  input  logic [2:0]             funct3_MEM,
  input  logic [31:0]            addr_MEM,
  input  logic [31:0]            wdata_MEM,
  mem_stage_lsu_if.master        dmem,
  output logic [31:0]            Mem_RD_MEM,
  output logic                   mem_valid,
  output logic                   mem_stall,
  output logic                   bus_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_t        state, state_next;
  logic [7:0]        cnt;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_be;
  logic [31:0]       req_dout;
  logic [2:0]        op_funct3;
  logic [1:0]        op_addr_lo;

  logic              mem_op;
  logic              misaligned_op;
  logic              accept;
  logic              ack_hit;
  logic              timeout_hit;
  logic [3:0]        st_be;
  logic [31:0]       st_dout;
  logic [31:0]       ld_data;
  logic              unused_addr_hi;

  assign mem_op         = valid_MEM & (MemRead_MEM | MemWrite_MEM);
  assign unused_addr_hi = ^addr_MEM[31:ADDR_W+2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned_op = is_misaligned(funct3_MEM, addr_MEM[1:0]);
`else
  assign misaligned_op = 1'b0;
`endif

  lsu_align u_align (
    .st_write   (MemWrite_MEM),
    .st_funct3  (funct3_MEM),
    .st_addr_lo (addr_MEM[1:0]),
    .st_data    (wdata_MEM),
    .st_be      (st_be),
    .st_dout    (st_dout),
    .ld_funct3  (op_funct3),
    .ld_addr_lo (op_addr_lo),
    .ld_raw     (dmem.D_MEM_DI),
    .ld_data    (ld_data)
  );

  assign dmem.D_MEM_REQ  = (state == REQ);
  assign dmem.D_MEM_WEN  = req_wen;
  assign dmem.D_MEM_ADDR = req_addr;
  assign dmem.D_MEM_BE   = req_be;
  assign dmem.D_MEM_DOUT = req_dout;

  // State register; a low RSTn at any edge abandons an in-flight request.
  always_ff @(posedge CLK) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus the combinational handshake toward the pipeline.
  always_comb begin
    state_next  = state;
    mem_valid   = 1'b0;
    mem_stall   = 1'b0;
    accept      = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_stall  = 1'b1;
          accept     = 1'b1;
          state_next = misaligned_op ? DONE : REQ;
        end else if (valid_MEM) begin
          mem_valid = 1'b1;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem.D_MEM_ACK) begin
          ack_hit    = 1'b1;
          state_next = DONE;
        end else if (cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        mem_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the op at acceptance, count REQ cycles, and capture the result/error.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt        <= '0;
      req_wen    <= 1'b0;
      req_addr   <= '0;
      req_be     <= '0;
      req_dout   <= '0;
      op_funct3  <= '0;
      op_addr_lo <= '0;
      Mem_RD_MEM <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (accept) begin
        cnt        <= '0;
        req_wen    <= MemWrite_MEM;
        req_addr   <= addr_MEM[ADDR_W+1:2];
        req_be     <= st_be;
        req_dout   <= st_dout;
        op_funct3  <= funct3_MEM;
        op_addr_lo <= addr_MEM[1:0];
        if (misaligned_op) begin
          Mem_RD_MEM <= '0;
          bus_err    <= 1'b1;
        end
      end
      if (state == REQ) cnt <= cnt + 8'd1;
      if (ack_hit) Mem_RD_MEM <= req_wen ? 32'd0 : ld_data;
      if (timeout_hit) begin
        Mem_RD_MEM <= '0;
        bus_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected results are queued when an op
// is driven and compared when mem_valid is seen.
module tb_mem_stage_lsu;
  import mem_lsu_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        valid_MEM, MemRead_MEM, MemWrite_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] addr_MEM, wdata_MEM;
  logic [31:0] Mem_RD_MEM;
  logic        mem_valid, mem_stall, bus_err;

  mem_stage_lsu_if #(.ADDR_W(ADDR_W)) dmem ();

  mem_stage_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .valid_MEM    (valid_MEM),
    .MemRead_MEM  (MemRead_MEM),
    .MemWrite_MEM (MemWrite_MEM),
    .funct3_MEM   (funct3_MEM),
    .addr_MEM     (addr_MEM),
    .wdata_MEM    (wdata_MEM),
    .dmem         (dmem),
    .Mem_RD_MEM   (Mem_RD_MEM),
    .mem_valid    (mem_valid),
    .mem_stall    (mem_stall),
    .bus_err      (bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cycles, stall_cycles, done_cycle;
  logic [ADDR_W-1:0] seen_addr;
  logic [3:0]        seen_be;
  logic              seen_wen;
  logic [31:0]       seen_dout;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    dmem.D_MEM_ACK = 1'b0;
    dmem.D_MEM_DI  = 32'd0;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
    valid_MEM    = v;
    MemRead_MEM  = rd;
    MemWrite_MEM = wr;
    funct3_MEM   = f3;
    addr_MEM     = a;
    wdata_MEM    = wd;
  endtask

  task automatic expectResult(input logic [31:0] rd, input logic err);
    sb_q.push_back('{rd: rd, err: err});
  endtask

  // Called right after an op is driven; acks on the ack_after-th REQ cycle (0 = never).
  task automatic runMemOp(input string tag, input int ack_after, input logic [31:0] di);
    bit   done = 1'b0;
    exp_t e;
    req_cycles   = 0;
    stall_cycles = 0;
    done_cycle   = -1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (mem_stall) stall_cycles++;
      if (dmem.D_MEM_REQ) begin
        req_cycles++;
        if (req_cycles == 1) begin
          seen_addr = dmem.D_MEM_ADDR;
          seen_be   = dmem.D_MEM_BE;
          seen_wen  = dmem.D_MEM_WEN;
          seen_dout = dmem.D_MEM_DOUT;
        end
        if (ack_after > 0 && req_cycles == ack_after) begin
          dmem.D_MEM_ACK = 1'b1;
          dmem.D_MEM_DI  = di;
        end
      end
      if (mem_valid) begin
        done       = 1'b1;
        done_cycle = cyc;
        checkOutput({tag, "_sb_pending"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checkOutput({tag, "_rd"}, Mem_RD_MEM, e.rd);
          checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'(e.err));
        end
        checkOutput({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
        checkOutput({tag, "_done_req"}, 32'(dmem.D_MEM_REQ), 32'd0);
      end else begin
        tick();
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // Upstream advances past DONE with a bubble; the unit must be quiet in IDLE.
  task automatic finishOp(input string tag);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    #1;
    checkOutput({tag, "_idle_err"}, 32'(bus_err), 32'd0);
    checkOutput({tag, "_idle_req"}, 32'(dmem.D_MEM_REQ), 32'd0);
    checkOutput({tag, "_idle_valid"}, 32'(mem_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RSTn           = 1'b0;
    dmem.D_MEM_ACK = 1'b0;
    dmem.D_MEM_DI  = 32'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    tick();
    tick();
    #1;
    checkOutput("rst_req", 32'(dmem.D_MEM_REQ), 32'd0);
    checkOutput("rst_wen", 32'(dmem.D_MEM_WEN), 32'd0);
    checkOutput("rst_addr", 32'(dmem.D_MEM_ADDR), 32'd0);
    checkOutput("rst_be", 32'(dmem.D_MEM_BE), 32'd0);
    checkOutput("rst_dout", dmem.D_MEM_DOUT, 32'd0);
    checkOutput("rst_rd", Mem_RD_MEM, 32'd0);
    checkOutput("rst_err", 32'(bus_err), 32'd0);
    checkOutput("rst_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    RSTn = 1'b1;

    $display("[TB] non-memory instruction");
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0040, 32'h1111_2222);
    #1;
    checkOutput("alu_valid", 32'(mem_valid), 32'd1);
    checkOutput("alu_stall", 32'(mem_stall), 32'd0);
    checkOutput("alu_req", 32'(dmem.D_MEM_REQ), 32'd0);
    tick();
    #1;
    checkOutput("alu_req_next", 32'(dmem.D_MEM_REQ), 32'd0);
    checkOutput("alu_valid_next", 32'(mem_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    #1;
    checkOutput("bubble_valid", 32'(mem_valid), 32'd0);

    $display("[TB] LB 0x103");
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, F3_B, 32'h0000_0103, 32'd0);
    expectResult(32'hFFFF_FF80, 1'b0);
    runMemOp("lb", 1, 32'h80FF_1234);
    checkOutput("lb_latency", 32'(done_cycle), 32'd2);
    checkOutput("lb_addr", 32'(seen_addr), 32'h040);
    checkOutput("lb_be", 32'(seen_be), 32'hF);
    checkOutput("lb_wen", 32'(seen_wen), 32'd0);
    finishOp("lb");

    $display("[TB] LBU 0x103");
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, F3_BU, 32'h0000_0103, 32'd0);
    expectResult(32'h0000_0080, 1'b0);
    runMemOp("lbu", 1, 32'h80FF_1234);
    checkOutput("lbu_latency", 32'(done_cycle), 32'd2);
    finishOp("lbu");

    $display("[TB] reset during SB request");
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, F3_B, 32'h0000_0021, 32'hAAAA_BB55);
    #1;
    checkOutput("rstm_accept_stall", 32'(mem_stall), 32'd1);
    tick();
    #1;
    checkOutput("rstm_req", 32'(dmem.D_MEM_REQ), 32'd1);
    checkOutput("rstm_wen", 32'(dmem.D_MEM_WEN), 32'd1);
    checkOutput("rstm_be", 32'(dmem.D_MEM_BE), 32'h2);
    checkOutput("rstm_dout", dmem.D_MEM_DOUT, 32'h5555_5555);
    checkOutput("rstm_addr", 32'(dmem.D_MEM_ADDR), 32'h008);
    tick();
    RSTn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    tick();
    RSTn           = 1'b1;
    dmem.D_MEM_ACK = 1'b1;
    dmem.D_MEM_DI  = 32'hFFFF_FFFF;
    #1;
    checkOutput("rstm_req_after", 32'(dmem.D_MEM_REQ), 32'd0);
    checkOutput("rstm_wen_after", 32'(dmem.D_MEM_WEN), 32'd0);
    checkOutput("rstm_addr_after", 32'(dmem.D_MEM_ADDR), 32'd0);
    checkOutput("rstm_be_after", 32'(dmem.D_MEM_BE), 32'd0);
    checkOutput("rstm_dout_after", dmem.D_MEM_DOUT, 32'd0);
    checkOutput("rstm_rd_after", Mem_RD_MEM, 32'd0);
    checkOutput("rstm_err_after", 32'(bus_err), 32'd0);
    checkOutput("rstm_valid_after", 32'(mem_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checkOutput("rstm_late_ack_req", 32'(dmem.D_MEM_REQ), 32'd0);
      checkOutput("rstm_late_ack_valid", 32'(mem_valid), 32'd0);
      checkOutput("rstm_late_ack_rd", Mem_RD_MEM, 32'd0);
    end

    $display("[TB] LH / LHU");
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, F3_H, 32'h0000_0102, 32'd0);
    expectResult(32'hFFFF_80FF, 1'b0);
    runMemOp("lh", 1, 32'h80FF_1234);
    finishOp("lh");
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, F3_HU, 32'h0000_0100, 32'd0);
    expectResult(32'h0000_1234, 1'b0);
    runMemOp("lhu", 2, 32'h80FF_1234);
    checkOutput("lhu_latency", 32'(done_cycle), 32'd3);
    finishOp("lhu");

    $display("[TB] SH 0x12 with three REQ cycles");
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, F3_H, 32'h0000_0012, 32'hDEAD_BEEF);
    expectResult(32'd0, 1'b0);
    runMemOp("sh", 3, 32'h1234_5678);
    checkOutput("sh_wen", 32'(seen_wen), 32'd1);
    checkOutput("sh_be", 32'(seen_be), 32'hC);
    checkOutput("sh_dout", seen_dout, 32'hBEEF_BEEF);
    checkOutput("sh_addr", 32'(seen_addr), 32'h004);
    checkOutput("sh_stall_cycles", 32'(stall_cycles), 32'd4);
    checkOutput("sh_req_cycles", 32'(req_cycles), 32'd3);
    finishOp("sh");

    $display("[TB] LW with no ack");
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0200, 32'd0);
    expectResult(32'd0, 1'b1);
    runMemOp("lw_to", 0, 32'd0);
    checkOutput("lw_to_req_cycles", 32'(req_cycles), 32'd16);
    checkOutput("lw_to_latency", 32'(done_cycle), 32'd17);
    checkOutput("lw_to_addr", 32'(seen_addr), 32'h080);
    finishOp("lw_to");

    $display("[TB] LW at misaligned 0x006");
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0006, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    expectResult(32'd0, 1'b1);
    runMemOp("lw_mis", 1, 32'hCAFE_F00D);
    checkOutput("lw_mis_req_cycles", 32'(req_cycles), 32'd0);
    checkOutput("lw_mis_latency", 32'(done_cycle), 32'd1);
`else
    expectResult(32'hCAFE_F00D, 1'b0);
    runMemOp("lw_mis", 1, 32'hCAFE_F00D);
    checkOutput("lw_mis_req_cycles", 32'(req_cycles), 32'd1);
    checkOutput("lw_mis_addr", 32'(seen_addr), 32'h001);
    checkOutput("lw_mis_be", 32'(seen_be), 32'hF);
    checkOutput("lw_mis_latency", 32'(done_cycle), 32'd2);
`endif
    finishOp("lw_mis");

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
